hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter M, default 4, SHALL set register-address width.
REQ-002 Parameter C, default 16, SHALL set performance-counter width.
REQ-003 Parameter TIMEOUT, default 255, SHALL set the memory-wait abort limit in cycles (8 bits).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Ports SHALL be:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- regA_addr_D, regB_addr_D  in  M  decode source addresses
- useA_D, useB_D  in  1  decode source actually read
- regA_addr_E, regB_addr_E  in  M  execute source addresses
- regScr_E  in  M  execute destination
- regw_E, regmem_E  in  1  execute writes register / is load
- regScr_M, regw_M  in  M, 1  memory-stage destination, write enable
- regScr_W, regw_W  in  M, 1  writeback destination, write enable
- branch_E  in  1  branch resolved taken in execute
- mem_req_M, mem_ack  in  1  data-memory request / acknowledge
- stall_F, stall_D, stall_E, stall_M  out  1  hold stage register
- flush_D, flush_E  out  1  clear stage register (drives depipe flush_E)
- fwdA_E, fwdB_E  out  2  operand forward select
- mem_timeout  out  1  sticky wait-abort error
- stall_cnt, flush_cnt  out  C  performance counters

Function
REQ-006 FSM states SHALL be RUN, LDSTALL, MEMWAIT; outputs are combinational from state and inputs.
REQ-007 Memory wait: mem_req_M=1 and mem_ack=0 SHALL assert all four stalls, no flush, and enter or remain in MEMWAIT.
REQ-008 MEMWAIT with mem_ack=1 SHALL deassert stalls that cycle and return to RUN next edge.
REQ-009 Load-use (regmem_E & regw_E & ((useA_D & regA_addr_D==regScr_E) | (useB_D & regB_addr_D==regScr_E))) SHALL assert stall_F, stall_D, flush_E for one cycle and enter LDSTALL.
REQ-010 LDSTALL SHALL return to RUN next edge unconditionally; load-use detection is evaluated normally there.
REQ-011 branch_E=1 SHALL assert flush_D and flush_E that cycle, no stalls.
REQ-012 Priority SHALL be memory wait > branch > load-use; branch during memory wait is deferred, the stall holding it in execute.
REQ-013 Forward select per operand SHALL be 2'b10 if regw_M and address matches regScr_M, else 2'b01 if regw_W and matches regScr_W, else 2'b00; all addresses, including 0, are forwardable.
REQ-014 stall_cnt SHALL increment on every cycle with stall_F=1; flush_cnt on every cycle with flush_E=1; both saturate at all-ones.

Reset
REQ-015 rst low SHALL immediately force state RUN, all stalls/flushes 0, fwd selects 2'b00, counters 0, mem_timeout 0, wait counter 0, including mid-MEMWAIT.

Configuration
REQ-016 With HAZARD_TIMEOUT_EN defined, an 8-bit wait counter SHALL count consecutive MEMWAIT cycles; on the TIMEOUT-th, mem_timeout SHALL set (sticky until reset), stalls deassert that cycle, and the FSM returns to RUN.
REQ-017 Without HAZARD_TIMEOUT_EN, mem_timeout SHALL be tied 0 and MEMWAIT SHALL persist until mem_ack.

Structure
REQ-018 Package hazard_pkg SHALL hold the state enum and constants FWD_NONE=2'b00, FWD_W=2'b01, FWD_M=2'b10.
REQ-019 Sub-module fwd_unit (single-operand comparator) SHALL be instantiated twice.

Verification
REQ-020 regmem_E=1, regw_E=1, regScr_E=3, regA_addr_D=3, useA_D=1 -> one cycle stall_F=stall_D=flush_E=1, then all 0, stall_cnt=1.
REQ-021 regw_M=1, regScr_M=5, regw_W=1, regScr_W=5, regA_addr_E=5 -> fwdA_E=2'b10; drop regw_M -> 2'b01.
REQ-022 branch_E=1 with simultaneous load-use -> flush_D=flush_E=1, stall_F=0, flush_cnt=1.
REQ-023 mem_req_M=1, mem_ack=0 for 4 cycles with branch_E=1 -> all stalls 1, flushes 0; ack cycle 5 -> stalls 0, flush_D=flush_E=1.
REQ-024 HAZARD_TIMEOUT_EN, TIMEOUT=10, mem_ack held 0 -> stalls drop on 10th wait cycle, mem_timeout=1 until rst low.
REQ-025 rst low during MEMWAIT -> all outputs 0 asynchronously, state RUN.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

endpackage

// File: rtl/hazard_ctrl_fwd.sv
// Single-operand forwarding comparator: memory-stage result wins over writeback.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int M = 4
) (
    input  logic [M-1:0] i_src_addr,
    input  logic [M-1:0] i_dst_M,
    input  logic         i_wen_M,
    input  logic [M-1:0] i_dst_W,
    input  logic         i_wen_W,
    output logic [1:0]   o_sel
);

    always_comb begin
        o_sel = FWD_NONE;
        if (i_wen_M && (i_src_addr == i_dst_M)) begin
            o_sel = FWD_M;
        end else if (i_wen_W && (i_src_addr == i_dst_W)) begin
            o_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait stalls, branch flushes, load-use bubbles, forwarding.
// Optional memory-wait abort is enabled with the HAZARD_TIMEOUT_EN macro.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int M       = 4,
    parameter int C       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] regA_addr_D,
    input  logic [M-1:0] regB_addr_D,
    input  logic         useA_D,
    input  logic         useB_D,
    input  logic [M-1:0] regA_addr_E,
    input  logic [M-1:0] regB_addr_E,
    input  logic [M-1:0] regScr_E,
    input  logic         regw_E,
    input  logic         regmem_E,
    input  logic [M-1:0] regScr_M,
    input  logic         regw_M,
    input  logic [M-1:0] regScr_W,
    input  logic         regw_W,
    input  logic         branch_E,
    input  logic         mem_req_M,
    input  logic         mem_ack,
    output logic         stall_F,
    output logic         stall_D,
    output logic         stall_E,
    output logic         stall_M,
    output logic         flush_D,
    output logic         flush_E,
    output logic [1:0]   fwdA_E,
    output logic [1:0]   fwdB_E,
    output logic         mem_timeout,
    output logic [C-1:0] stall_cnt,
    output logic [C-1:0] flush_cnt
);

    state_t         r_state;
    state_t         w_next;
    logic           w_wait;
    logic           w_load_use;
    logic           w_tmo_hit;
    logic [1:0]     w_fwdA;
    logic [1:0]     w_fwdB;
    logic [C-1:0]   r_stall_cnt;
    logic [C-1:0]   r_flush_cnt;

    assign w_wait     = mem_req_M & ~mem_ack;
    assign w_load_use = regmem_E & regw_E &
                        ((useA_D & (regA_addr_D == regScr_E)) |
                         (useB_D & (regB_addr_D == regScr_E)));

`ifdef HAZARD_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] r_wait_cnt;
    logic       r_timeout;

    // The abort cycle itself releases the stalls, so the counter restarts there.
    assign w_tmo_hit = w_wait && (r_wait_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wait_cnt <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout  <= r_timeout | w_tmo_hit;
            r_wait_cnt <= (w_wait && !w_tmo_hit) ? r_wait_cnt + 8'd1 : 8'd0;
        end
    end

    assign mem_timeout = rst & (r_timeout | w_tmo_hit);
`else
    assign w_tmo_hit   = 1'b0;
    assign mem_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_next;
        end
    end

    // Priority: memory wait, then branch, then load-use. A deferred branch stays in execute.
    always_comb begin
        w_next  = RUN;
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        if (w_wait && !w_tmo_hit) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            stall_M = 1'b1;
            w_next  = MEMWAIT;
        end else if (branch_E) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
        end else if (w_load_use) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
            w_next  = (r_state == LDSTALL) ? RUN : LDSTALL;
        end
        if (!rst) begin
            w_next  = RUN;
            stall_F = 1'b0;
            stall_D = 1'b0;
            stall_E = 1'b0;
            stall_M = 1'b0;
            flush_D = 1'b0;
            flush_E = 1'b0;
        end
    end

    fwd_unit #(.M(M)) u_fwd_a (
        .i_src_addr (regA_addr_E),
        .i_dst_M    (regScr_M),
        .i_wen_M    (regw_M),
        .i_dst_W    (regScr_W),
        .i_wen_W    (regw_W),
        .o_sel      (w_fwdA)
    );

    fwd_unit #(.M(M)) u_fwd_b (
        .i_src_addr (regB_addr_E),
        .i_dst_M    (regScr_M),
        .i_wen_M    (regw_M),
        .i_dst_W    (regScr_W),
        .i_wen_W    (regw_W),
        .o_sel      (w_fwdB)
    );

    assign fwdA_E = rst ? w_fwdA : FWD_NONE;
    assign fwdB_E = rst ? w_fwdB : FWD_NONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_F && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (flush_E && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a rule-level reference model.
module tb_hazard_ctrl;

    localparam int M   = 4;
    localparam int C   = 4;
    localparam int TMO = 10;
    localparam int CMAX = (1 << C) - 1;
`ifdef HAZARD_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [M-1:0] regA_addr_D, regB_addr_D, regA_addr_E, regB_addr_E;
    logic [M-1:0] regScr_E, regScr_M, regScr_W;
    logic         useA_D, useB_D, regw_E, regmem_E, regw_M, regw_W;
    logic         branch_E, mem_req_M, mem_ack;
    logic         stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, mem_timeout;
    logic [1:0]   fwdA_E, fwdB_E;
    logic [C-1:0] stall_cnt, flush_cnt;

    int n_chk = 0;
    int n_err = 0;
    int m_run, m_scnt, m_fcnt;
    bit m_sticky;

    hazard_ctrl #(.M(M), .C(C), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .regA_addr_D(regA_addr_D), .regB_addr_D(regB_addr_D),
        .useA_D(useA_D), .useB_D(useB_D),
        .regA_addr_E(regA_addr_E), .regB_addr_E(regB_addr_E),
        .regScr_E(regScr_E), .regw_E(regw_E), .regmem_E(regmem_E),
        .regScr_M(regScr_M), .regw_M(regw_M),
        .regScr_W(regScr_W), .regw_W(regw_W),
        .branch_E(branch_E), .mem_req_M(mem_req_M), .mem_ack(mem_ack),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E),
        .fwdA_E(fwdA_E), .fwdB_E(fwdB_E),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int fwd_ref(input logic [M-1:0] a);
        if (regw_M && a == regScr_M) return 2;
        if (regw_W && a == regScr_W) return 1;
        return 0;
    endfunction

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        regA_addr_D = '0; regB_addr_D = '0; regA_addr_E = '0; regB_addr_E = '0;
        regScr_E = '0; regScr_M = '0; regScr_W = '0;
        useA_D = 0; useB_D = 0; regw_E = 0; regmem_E = 0; regw_M = 0; regw_W = 0;
        branch_E = 0; mem_req_M = 0; mem_ack = 0;
    endtask

    task automatic check_cycle();
        bit w, hit, lu;
        bit e_sF, e_sD, e_sE, e_sM, e_fD, e_fE, e_tmo;
        #3;
        if (!rst) begin
            m_run = 0; m_sticky = 0; m_scnt = 0; m_fcnt = 0;
        end
        w   = mem_req_M && !mem_ack;
        hit = TMO_EN && w && (m_run == TMO - 1);
        lu  = regmem_E && regw_E && ((useA_D && regA_addr_D == regScr_E) ||
                                     (useB_D && regB_addr_D == regScr_E));
        {e_sF, e_sD, e_sE, e_sM, e_fD, e_fE} = '0;
        if (rst) begin
            if (w && !hit) {e_sF, e_sD, e_sE, e_sM} = 4'hF;
            else if (branch_E) {e_fD, e_fE} = 2'b11;
            else if (lu) {e_sF, e_sD, e_fE} = 3'b111;
        end
        e_tmo = rst && TMO_EN && (m_sticky || hit);
        chk_eq("stall_F", 32'(stall_F), 32'(e_sF));
        chk_eq("stall_D", 32'(stall_D), 32'(e_sD));
        chk_eq("stall_E", 32'(stall_E), 32'(e_sE));
        chk_eq("stall_M", 32'(stall_M), 32'(e_sM));
        chk_eq("flush_D", 32'(flush_D), 32'(e_fD));
        chk_eq("flush_E", 32'(flush_E), 32'(e_fE));
        chk_eq("fwdA_E", 32'(fwdA_E), rst ? fwd_ref(regA_addr_E) : 0);
        chk_eq("fwdB_E", 32'(fwdB_E), rst ? fwd_ref(regB_addr_E) : 0);
        chk_eq("mem_timeout", 32'(mem_timeout), 32'(e_tmo));
        chk_eq("stall_cnt", 32'(stall_cnt), m_scnt);
        chk_eq("flush_cnt", 32'(flush_cnt), m_fcnt);
        if (rst) begin
            if (e_sF && m_scnt < CMAX) m_scnt++;
            if (e_fE && m_fcnt < CMAX) m_fcnt++;
            m_sticky = m_sticky || hit;
            m_run = (w && !hit) ? m_run + 1 : 0;
        end
    endtask

    task automatic do_reset();
        advance();
        clear_inputs();
        rst = 0;
        check_cycle();
        advance();
        rst = 1;
        check_cycle();
    endtask

    initial begin
        rst = 0;
        clear_inputs();
        m_run = 0; m_sticky = 0; m_scnt = 0; m_fcnt = 0;
        check_cycle();
        do_reset();

        // load-use bubble
        advance();
        regmem_E = 1; regw_E = 1; regScr_E = 3; regA_addr_D = 3; useA_D = 1;
        check_cycle();
        chk_eq("lu_stall_F", 32'(stall_F), 1);
        advance();
        clear_inputs();
        check_cycle();
        chk_eq("lu_after_stall_F", 32'(stall_F), 0);
        chk_eq("lu_stall_cnt", 32'(stall_cnt), 1);

        // forwarding priority, address 5 then address 0
        advance();
        regw_M = 1; regScr_M = 5; regw_W = 1; regScr_W = 5; regA_addr_E = 5;
        check_cycle();
        chk_eq("fwd_m", 32'(fwdA_E), 2);
        advance();
        regw_M = 0;
        check_cycle();
        chk_eq("fwd_w", 32'(fwdA_E), 1);
        advance();
        regw_M = 1; regScr_M = 0; regB_addr_E = 0;
        check_cycle();
        chk_eq("fwd_zero", 32'(fwdB_E), 2);

        // branch beats load-use
        do_reset();
        advance();
        branch_E = 1; regmem_E = 1; regw_E = 1; regScr_E = 3; regA_addr_D = 3; useA_D = 1;
        check_cycle();
        chk_eq("br_stall_F", 32'(stall_F), 0);
        chk_eq("br_flush_D", 32'(flush_D), 1);
        advance();
        clear_inputs();
        check_cycle();
        chk_eq("br_flush_cnt", 32'(flush_cnt), 1);

        // branch deferred behind a memory wait
        do_reset();
        for (int i = 0; i < 4; i++) begin
            advance();
            mem_req_M = 1; mem_ack = 0; branch_E = 1;
            check_cycle();
            chk_eq("mw_stall_M", 32'(stall_M), 1);
            chk_eq("mw_flush_E", 32'(flush_E), 0);
        end
        advance();
        mem_ack = 1;
        check_cycle();
        chk_eq("ack_stall_F", 32'(stall_F), 0);
        chk_eq("ack_flush_D", 32'(flush_D), 1);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 500; i++) begin
            advance();
            regA_addr_D = 4'($urandom_range(0, 3)); regB_addr_D = 4'($urandom_range(0, 3));
            regA_addr_E = 4'($urandom_range(0, 3)); regB_addr_E = 4'($urandom_range(0, 3));
            regScr_E = 4'($urandom_range(0, 3)); regScr_M = 4'($urandom_range(0, 3));
            regScr_W = 4'($urandom_range(0, 3));
            useA_D = 1'($urandom); useB_D = 1'($urandom);
            regw_E = 1'($urandom); regmem_E = 1'($urandom);
            regw_M = 1'($urandom); regw_W = 1'($urandom);
            branch_E = ($urandom_range(0, 4) == 0);
            mem_req_M = ($urandom_range(0, 3) == 0);
            mem_ack = 1'($urandom);
            check_cycle();
        end

        // long memory wait: aborts on the TMO-th cycle when enabled
        do_reset();
        for (int i = 1; i <= TMO + 2; i++) begin
            advance();
            mem_req_M = 1; mem_ack = 0;
            check_cycle();
            if (i == TMO) begin
                chk_eq("tmo_stall_F", 32'(stall_F), TMO_EN ? 0 : 1);
                chk_eq("tmo_flag", 32'(mem_timeout), 32'(TMO_EN));
            end
        end
        advance();
        mem_req_M = 0;
        check_cycle();
        chk_eq("tmo_sticky", 32'(mem_timeout), 32'(TMO_EN));

        // asynchronous reset in the middle of a wait
        advance();
        mem_req_M = 1; mem_ack = 0; branch_E = 1;
        check_cycle();
        advance();
        #1;
        rst = 0;
        #1;
        chk_eq("async_stall_F", 32'(stall_F), 0);
        chk_eq("async_cnt", 32'(stall_cnt), 0);
        chk_eq("async_tmo", 32'(mem_timeout), 0);
        check_cycle();
        advance();
        rst = 1;
        mem_req_M = 0; branch_E = 0;
        check_cycle();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
